// File: rtl/snn_wb_sequencer.sv
// Wishbone classic master sequencer: buffers valid/ready commands in a FIFO and issues them one at a time.
// Optional watchdog abort of unacknowledged cycles is enabled by defining SNN_SEQ_TIMEOUT_EN.
module snn_wb_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_we,
  input  logic [31:0]                    cmd_adr,
  input  logic [31:0]                    cmd_dat,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_dat,
  output logic                           rsp_err,
  output logic                           m_cyc_o,
  output logic                           m_stb_o,
  output logic                           m_we_o,
  output logic [3:0]                     m_sel_o,
  output logic [31:0]                    m_adr_o,
  output logic [31:0]                    m_dat_o,
  input  logic [31:0]                    m_dat_i,
  input  logic                           m_ack_i,
  output logic                           busy,
  output logic [$clog2(CMD_DEPTH):0]     cmd_count
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t         state_reg, state_next;
  logic [64:0]    fifo_mem [CMD_DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg, count_next;
  logic           push, pop, timeout_hit;
  logic [64:0]    head;

  logic           cyc_reg, cyc_next, stb_reg, stb_next, we_reg, we_next;
  logic [3:0]     sel_reg, sel_next;
  logic [31:0]    adr_reg, adr_next, dat_reg, dat_next;
  logic           rsp_valid_reg, rsp_valid_next, rsp_err_reg, rsp_err_next;
  logic [31:0]    rsp_dat_reg, rsp_dat_next;

  // Readiness comes from the registered occupancy only, so a pop never frees a slot in the same cycle.
  assign cmd_ready = !wb_rst_i && (count_reg != CW'(CMD_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr_reg];

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= {cmd_we, cmd_adr, cmd_dat};
  end

`ifdef SNN_SEQ_TIMEOUT_EN
  logic [15:0] timer_reg;

  // Counter sits at zero in IDLE, so it is cleared on every REQ entry.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_reg == IDLE) timer_reg <= '0;
    else if (!m_ack_i)                 timer_reg <= timer_reg + 16'd1;
  end

  assign timeout_hit = (state_reg == REQ) && !m_ack_i && (timer_reg == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    pop            = 1'b0;
    cyc_next       = cyc_reg;
    stb_next       = stb_reg;
    we_next        = we_reg;
    sel_next       = sel_reg;
    adr_next       = adr_reg;
    dat_next       = dat_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_dat_next   = rsp_dat_reg;
    rsp_err_next   = rsp_err_reg;

    if (rsp_valid_reg && rsp_ready) rsp_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (count_reg != '0 && !rsp_valid_reg) begin
          state_next = REQ;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          sel_next   = 4'hF;
          we_next    = head[64];
          adr_next   = head[63:32];
          dat_next   = head[31:0];
        end
      end
      REQ: begin
        if (m_ack_i || timeout_hit) begin
          state_next     = IDLE;
          pop            = 1'b1;
          cyc_next       = 1'b0;
          stb_next       = 1'b0;
          sel_next       = 4'h0;
          we_next        = 1'b0;
          adr_next       = '0;
          dat_next       = '0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = !m_ack_i;
          rsp_dat_next   = (m_ack_i && !we_reg) ? m_dat_i : 32'h0;
        end
      end
      default: state_next = IDLE;
    endcase

    count_next = count_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= 4'h0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      cyc_reg       <= cyc_next;
      stb_reg       <= stb_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      adr_reg       <= adr_next;
      dat_reg       <= dat_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_dat_reg   <= rsp_dat_next;
      rsp_err_reg   <= rsp_err_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  assign m_cyc_o   = cyc_reg;
  assign m_stb_o   = stb_reg;
  assign m_we_o    = we_reg;
  assign m_sel_o   = sel_reg;
  assign m_adr_o   = adr_reg;
  assign m_dat_o   = dat_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_dat   = rsp_dat_reg;
  assign rsp_err   = rsp_err_reg;
  assign cmd_count = count_reg;
  assign busy      = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_snn_wb_sequencer.sv
// Scoreboard bench for snn_wb_sequencer: stimulus pushes expected bus/response items, slave and monitor check them.
// Define SNN_SEQ_TIMEOUT_EN to include the watchdog scenarios.
module tb_snn_wb_sequencer;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i, cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] cmd_adr, cmd_dat, rsp_dat, m_adr_o, m_dat_o, m_dat_i;
  logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i, busy;
  logic [3:0]  m_sel_o;
  logic [2:0]  cmd_count;

  always #5 wb_clk_i = ~wb_clk_i;

  snn_wb_sequencer #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .busy(busy), .cmd_count(cmd_count)
  );

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          wait_n;
    logic [31:0] rdata;
    int          len;
  } bus_t;
  typedef struct {
    logic [31:0] dat;
    bit          err;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   vectors = 0, miscompares = 0;
  bit   stall = 0, force_ack = 0;
  int   cyc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: acks the head item after its wait states, checks bus fields and strobe length.
  always @(negedge wb_clk_i) begin
    if (m_stb_o) begin
      cyc_cnt++;
      if (bus_q.size() > 0 && cyc_cnt == 1) begin
        check("bus_adr", m_adr_o, bus_q[0].adr);
        check("bus_we", {31'd0, m_we_o}, {31'd0, bus_q[0].we});
        check("bus_sel", {28'd0, m_sel_o}, 32'hF);
        check("bus_cyc", {31'd0, m_cyc_o}, 32'd1);
        if (bus_q[0].we) check("bus_dat", m_dat_o, bus_q[0].dat);
      end
      if (bus_q.size() > 0 && !stall && cyc_cnt >= bus_q[0].wait_n + 1) begin
        m_ack_i = 1'b1;
        m_dat_i = bus_q[0].rdata;
      end else begin
        m_ack_i = 1'b0;
        m_dat_i = 32'hDEAD_BEEF;
      end
    end else begin
      if (cyc_cnt > 0 && bus_q.size() > 0) begin
        if (bus_q[0].len > 0) check("stb_len", cyc_cnt, bus_q[0].len);
        void'(bus_q.pop_front());
      end
      cyc_cnt = 0;
      m_ack_i = force_ack;
      m_dat_i = 32'hDEAD_BEEF;
    end
  end

  // Response monitor: one comparison pair per accepted response.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got dat=%h err=%b expected none", rsp_dat, rsp_err);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_dat", rsp_dat, e.dat);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic push(input bit we, input logic [31:0] adr, input logic [31:0] dat, input int wait_n,
                      input logic [31:0] rdata, input int len, input bit err);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
    while (!cmd_ready && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: got cmd_ready=0 expected 1 within 200 cycles");
      return;
    end
    bus_q.push_back('{we, adr, dat, wait_n, rdata, len});
    rsp_q.push_back('{(we || err) ? 32'h0 : rdata, err});
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rsp_valid || bus_q.size() != 0 || rsp_q.size() != 0) && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("drain", n < 300, 32'd1);
  endtask

  initial begin
    int hi;
    wb_rst_i = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_adr = '0; cmd_dat = '0; m_ack_i = 1'b0; m_dat_i = '0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("rst_cyc", {31'd0, m_cyc_o}, 32'd0);
    check("rst_sel", {28'd0, m_sel_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, cmd_count}, 32'd0);

    // Single write, zero-wait slave
    push(1'b1, 32'h3000_0004, 32'hA5A5_0001, 0, 32'h0, 1, 1'b0);
    check("wr_cyc_e0", {31'd0, m_cyc_o}, 32'd0);
    check("wr_count", {29'd0, cmd_count}, 32'd1);
    @(negedge wb_clk_i);
    check("wr_stb_e1", {31'd0, m_stb_o}, 32'd1);
    check("wr_m_dat", m_dat_o, 32'hA5A5_0001);
    @(negedge wb_clk_i);
    check("wr_stb_done", {31'd0, m_stb_o}, 32'd0);
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    wait_idle();

    // Read with three wait states
    push(1'b0, 32'h3000_0008, 32'h0, 3, 32'h1234_5678, 4, 1'b0);
    wait_idle();

    // Fill FIFO with slave stalled
    stall = 1'b1;
    push(1'b1, 32'h3000_0010, 32'h0000_0001, 0, 32'h0, 0, 1'b0);
    push(1'b0, 32'h3000_0014, 32'h0, 1, 32'h0000_0002, 2, 1'b0);
    push(1'b1, 32'h3000_0018, 32'h0000_0003, 1, 32'h0, 2, 1'b0);
    push(1'b0, 32'h3000_001C, 32'h0, 1, 32'h0000_0004, 2, 1'b0);
    check("full_ready", {31'd0, cmd_ready}, 32'd0);
    check("full_count", {29'd0, cmd_count}, 32'd4);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0000_0005;
    repeat (3) @(negedge wb_clk_i);
    check("full_held", {29'd0, cmd_count}, 32'd4);
    stall = 1'b0;
    push(1'b1, 32'h3000_0020, 32'h0000_0005, 1, 32'h0, 2, 1'b0);
    wait_idle();

    // Response backpressure
    rsp_ready = 1'b0;
    push(1'b1, 32'h4000_0000, 32'h1111_1111, 0, 32'h0, 1, 1'b0);
    push(1'b0, 32'h4000_0004, 32'h0, 0, 32'hCAFE_0002, 1, 1'b0);
    hi = 0;
    while (!rsp_valid && hi < 50) begin
      @(negedge wb_clk_i);
      hi++;
    end
    hi = 0;
    repeat (10) begin
      @(negedge wb_clk_i);
      if (m_stb_o) hi++;
    end
    check("bp_stb_held", hi, 32'd0);
    check("bp_rsp_held", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    check("bp_rsp_clear", {31'd0, rsp_valid}, 32'd0);
    check("bp_stb_still_low", {31'd0, m_stb_o}, 32'd0);
    @(negedge wb_clk_i);
    check("bp_stb_rise", {31'd0, m_stb_o}, 32'd1);
    wait_idle();

`ifdef SNN_SEQ_TIMEOUT_EN
    // Watchdog abort, then ack exactly at the expiry edge
    push(1'b0, 32'h5000_0000, 32'h0, 1000, 32'h0, 8, 1'b1);
    wait_idle();
    push(1'b0, 32'h5000_0004, 32'h0, 7, 32'h8765_4321, 8, 1'b0);
    wait_idle();
`endif

    // Reset in the middle of a request with a second command queued
    stall = 1'b1;
    push(1'b1, 32'h6000_0000, 32'h0000_00AA, 0, 32'h0, 0, 1'b0);
    push(1'b1, 32'h6000_0004, 32'h0000_00BB, 0, 32'h0, 0, 1'b0);
    hi = 0;
    while (!m_stb_o && hi < 20) begin
      @(negedge wb_clk_i);
      hi++;
    end
    check("rr_stb_before", {31'd0, m_stb_o}, 32'd1);
    bus_q.delete();
    rsp_q.delete();
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rr_cyc", {31'd0, m_cyc_o}, 32'd0);
    check("rr_stb", {31'd0, m_stb_o}, 32'd0);
    check("rr_count", {29'd0, cmd_count}, 32'd0);
    check("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    wb_rst_i = 1'b0;
    stall = 1'b0;
    force_ack = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    force_ack = 1'b0;
    hi = 0;
    repeat (6) begin
      @(negedge wb_clk_i);
      if (m_stb_o || rsp_valid) hi++;
    end
    check("rr_quiet", hi, 32'd0);
    check("rr_busy", {31'd0, busy}, 32'd0);

    check("end_rsp_q", rsp_q.size(), 32'd0);
    check("end_bus_q", bus_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "simulation time limit");
  end
endmodule
